// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat AXI master between the fetch read port and the mem-stage data port.
// Data wins arbitration unless it has already taken MAX_DATA_STREAK grants in a row while fetch waited.
module mem_bus_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  inst_req_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  output logic                  inst_busy_o,
  output logic                  inst_done_o,
  output logic [31:0]           inst_rdata_o,
  input  logic                  data_ce_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [3:0]            data_sel_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_busy_o,
  output logic                  data_done_o,
  output logic [31:0]           data_rdata_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [31:0]           rdata_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic                  bvalid_i,
  output logic                  bready_o
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_RESP, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_gnt_data;
  logic                  r_drop;
  logic [STREAK_W-1:0]   r_streak;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_sel;
  logic [31:0]           r_wdata;
  logic [31:0]           r_inst_rdata;
  logic [31:0]           r_data_rdata;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_inst_done;
  logic                  r_data_done;

  logic w_grant_data;
  logic w_grant_inst;
  logic w_drop;
  logic w_aw_done;
  logic w_w_done;

  assign w_grant_data = data_ce_i && (!inst_req_i || (r_streak < STREAK_MAX));
  assign w_grant_inst = !w_grant_data && inst_req_i && !flush_i;
  // A flush arriving in the same cycle as rvalid must still suppress the fetch done.
  assign w_drop       = r_drop || (flush_i && !r_gnt_data);
  assign w_aw_done    = !r_awvalid || awready_i;
  assign w_w_done     = !r_wvalid || wready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_gnt_data   <= 1'b0;
      r_drop       <= 1'b0;
      r_streak     <= '0;
      r_addr       <= '0;
      r_sel        <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
    end else begin
      if (r_state != S_IDLE && flush_i && !r_gnt_data) begin
        r_drop <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_gnt_data <= 1'b1;
            r_addr     <= data_addr_i;
            r_sel      <= data_sel_i;
            r_wdata    <= data_wdata_i;
            if (!inst_req_i) begin
              r_streak <= '0;
            end else if (r_streak < STREAK_MAX) begin
              r_streak <= r_streak + 1'b1;
            end
            if (data_we_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_ADDR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end else if (w_grant_inst) begin
            r_gnt_data <= 1'b0;
            r_addr     <= inst_addr_i;
            r_streak   <= '0;
            r_arvalid  <= 1'b1;
            r_state    <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid_i) begin
            r_rready <= 1'b0;
            if (r_gnt_data) begin
              r_data_rdata <= rdata_i;
              r_data_done  <= 1'b1;
            end else begin
              r_inst_rdata <= rdata_i;
              r_inst_done  <= !w_drop;
            end
            r_state <= S_DONE;
          end
        end
        S_WR_ADDR: begin
          if (awready_i) begin
            r_awvalid <= 1'b0;
          end
          if (wready_i) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid_i) begin
            r_bready    <= 1'b0;
            r_data_done <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_inst_done <= 1'b0;
          r_data_done <= 1'b0;
          r_drop      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst_done_o  = r_inst_done;
  assign inst_busy_o  = inst_req_i && !r_inst_done;
  assign inst_rdata_o = r_inst_rdata;
  assign data_done_o  = r_data_done;
  assign data_busy_o  = data_ce_i && !r_data_done;
  assign data_rdata_o = r_data_rdata;
  assign araddr_o     = r_addr;
  assign arvalid_o    = r_arvalid;
  assign rready_o     = r_rready;
  assign awaddr_o     = r_addr;
  assign awvalid_o    = r_awvalid;
  assign wdata_o      = r_wdata;
  assign wstrb_o      = r_sel;
  assign wvalid_o     = r_wvalid;
  assign bready_o     = r_bready;

endmodule
